mux41_rr_arbiter: RTL and testbench
===================================

Name: mux41_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 mux datapath among four requesters.
- Drives the mux select pair from a registered one-hot grant, so exactly one requester owns the mux at a time.
- Sits directly in front of the mux41 instance: sel[1] feeds s1, sel[0] feeds s0.
- Bounds ownership with a configurable hold limit so no requester can starve the others.

Parameters:
- MAX_HOLD, default 4: maximum consecutive grant cycles per ownership; 0 = unlimited (release only on req drop); legal range 0..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  input  4  request vector; req[i] high = requester i wants the mux; level-sensitive, held until done.
- gnt  output  4  registered one-hot grant; all-zero when no owner.
- sel  output  2  mux select = binary index of owner; sel[1] drives s1, sel[0] drives s0.
- busy  output  1  high while a grant is active (gnt != 0).
- preempt  output  1  one-cycle pulse, high in the cycle the grant is removed because of hold-limit expiry.

Behaviour:
- Reset (rst_n low at a clk edge): gnt=4'b0000, sel=2'b00, busy=0, preempt=0, hold_cnt=0, last_owner=2'd3 (so requester 0 has first priority), state=IDLE. Reset overrides every other event, including an active grant.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req != 0: select the first asserted req in the order last_owner+1, +2, +3, +4 (mod 4).
  - Next edge: gnt=onehot(winner), sel=winner, busy=1, hold_cnt=0, go to GRANT.
  - Latency from req assertion to gnt: 1 cycle.
  - If req == 0: stay in IDLE, gnt=0, sel holds its previous value.
- GRANT, on each edge:
  - If req[owner]==0 (normal release): gnt=0, busy=0, preempt=0, last_owner=owner, go to IDLE.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 (forced release): gnt=0, busy=0, preempt=1 for one cycle, last_owner=owner, go to IDLE.
  - Else: hold_cnt+1, grant unchanged.
- An ownership therefore lasts at most MAX_HOLD cycles of gnt high.
- Between any two grants there is exactly one IDLE cycle with gnt=0; there are no back-to-back grants.
- hold_cnt is 8 bits wide and resets to 0 on every new grant. With MAX_HOLD=0 it saturates at 255 and never wraps.
- Simultaneous req drop and hold expiry: treated as a normal release, preempt=0.
- Changes on req of non-owners during GRANT: ignored until the next IDLE cycle.
- A preempted owner that keeps req high is re-arbitrated normally. It wins again only if no other requester is asserted.
- sel is stable for the whole grant and never changes while busy=1.
- gnt is always one-hot or zero; sel == index(gnt) whenever busy=1.

Optional Feature:
- Macro: MUX41_ARB_PRIO0_EN.
- Defined: requester 0 is a priority port.
  - In IDLE, if req[0]=1, requester 0 wins regardless of last_owner.
  - Requester 0's grant ignores MAX_HOLD and ends only when req[0] drops; preempt never pulses for requester 0.
  - Requesters 1..3 still rotate round-robin among themselves.
- Undefined: all four requesters are equal round-robin peers as described above.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0000, sel=00, busy=0, preempt=0 throughout; first cycle after rst_n=1 -> gnt=0001 at the next edge.
- Single requester: req=0100 for 3 cycles, then 0000 -> gnt=0100 and sel=10 one cycle after req; gnt=0000 one cycle after req drops; preempt=0.
- Full contention, MAX_HOLD=4, req=1111 constant -> grant order 0,1,2,3,0; each gnt high exactly 4 cycles; 1-cycle gap; preempt pulses at each handover; sel tracks 00,01,10,11,00.
- Simultaneous events, MAX_HOLD=4: owner 1 drops req in its 4th grant cycle -> release with preempt=0; next grant goes to requester 2 if asserted.
- Reset mid-grant: owner 3 at hold_cnt=2, then rst_n=0 for one edge -> gnt=0 and last_owner=3; with req=1010 after reset, next grant is requester 1.
- MUX41_ARB_PRIO0_EN defined, MAX_HOLD=2, req=1111 -> requester 0 granted first and held until req[0] drops (e.g. 10 cycles) with no preempt; then requesters 1,2,3 rotate at 2 cycles each.

Source files
------------

// File: rtl/mux41_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux41 arbiter.
// The arbiter takes the slave side; requesters drive through master.
interface mux41_rr_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output busy,
        output preempt
    );
endinterface

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter owning the select pair of a 4:1 mux, with hold limit.
// Define MUX41_ARB_PRIO0_EN to make requester 0 a non-preemptible priority port.
module mux41_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input logic                clk,
    input logic                rst_n,
    mux41_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    localparam bit          HOLD_EN = (MAX_HOLD != 0);
    localparam int unsigned HOLD_LM = HOLD_EN ? MAX_HOLD - 1 : 0;
    localparam logic [7:0]  HOLD_LAST = HOLD_LM[7:0];

    state_e      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [1:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        preempt_q, preempt_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [1:0]  last_owner_q, last_owner_d;

    logic [1:0]  winner;
    logic [1:0]  cand;
    logic        found;
    logic        expire;

    // Scan starting just after the last owner so every requester gets a turn.
    always_comb begin
        winner = last_owner_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_owner_q + k[1:0];
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef MUX41_ARB_PRIO0_EN
        if (bus.req[0]) begin
            winner = 2'd0;
        end
`endif
    end

`ifdef MUX41_ARB_PRIO0_EN
    assign expire = HOLD_EN && (hold_cnt_q == HOLD_LAST) && (sel_q != 2'd0);
`else
    assign expire = HOLD_EN && (hold_cnt_q == HOLD_LAST);
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        busy_d       = busy_q;
        preempt_d    = 1'b0;
        hold_cnt_d   = hold_cnt_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d    = GRANT;
                    gnt_d      = 4'b0001 << winner;
                    sel_d      = winner;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd0;
                end else begin
                    gnt_d  = 4'b0000;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                // A request drop wins over expiry, so no preempt pulse then.
                if (!bus.req[sel_q] || expire) begin
                    state_d      = IDLE;
                    gnt_d        = 4'b0000;
                    busy_d       = 1'b0;
                    preempt_d    = bus.req[sel_q];
                    last_owner_d = sel_q;
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= 4'b0000;
            sel_q        <= 2'b00;
            busy_q       <= 1'b0;
            preempt_q    <= 1'b0;
            hold_cnt_q   <= 8'd0;
            last_owner_q <= 2'd3;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            preempt_q    <= preempt_d;
            hold_cnt_q   <= hold_cnt_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.busy    = busy_q;
    assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed vector bench for mux41_rr_arbiter.
// Covers both the default build and MUX41_ARB_PRIO0_EN.
module tb_mux41_rr_arbiter;

`ifdef MUX41_ARB_PRIO0_EN
    localparam int MH = 2;
`else
    localparam int MH = 4;
`endif

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       pre;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux41_rr_arbiter_if bus();

    mux41_rr_arbiter #(.MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic addn(input int n, input logic r, input logic [3:0] q,
                        input logic [3:0] g, input logic [1:0] s,
                        input logic b, input logic p);
        vec_t v;
        v.rst_n = r; v.req = q; v.gnt = g;
        v.sel = s; v.busy = b; v.pre = p;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.req = 4'b0000;
`ifdef MUX41_ARB_PRIO0_EN
        addn(2,  0, 4'hF, 4'h0, 2'd0, 0, 0);
        addn(10, 1, 4'hF, 4'h1, 2'd0, 1, 0);
        addn(1,  1, 4'hE, 4'h0, 2'd0, 0, 0);
        addn(2,  1, 4'hE, 4'h2, 2'd1, 1, 0);
        addn(1,  1, 4'hE, 4'h0, 2'd1, 0, 1);
        addn(2,  1, 4'hE, 4'h4, 2'd2, 1, 0);
        addn(1,  1, 4'hE, 4'h0, 2'd2, 0, 1);
        addn(2,  1, 4'hE, 4'h8, 2'd3, 1, 0);
        addn(1,  1, 4'hE, 4'h0, 2'd3, 0, 1);
        addn(1,  1, 4'hE, 4'h2, 2'd1, 1, 0);
        addn(1,  1, 4'h0, 4'h0, 2'd1, 0, 0);
        addn(3,  1, 4'hF, 4'h1, 2'd0, 1, 0);
        addn(1,  1, 4'h0, 4'h0, 2'd0, 0, 0);
`else
        addn(2, 0, 4'hF, 4'h0, 2'd0, 0, 0);
        addn(4, 1, 4'hF, 4'h1, 2'd0, 1, 0);
        addn(1, 1, 4'hF, 4'h0, 2'd0, 0, 1);
        addn(4, 1, 4'hF, 4'h2, 2'd1, 1, 0);
        addn(1, 1, 4'hF, 4'h0, 2'd1, 0, 1);
        addn(4, 1, 4'hF, 4'h4, 2'd2, 1, 0);
        addn(1, 1, 4'hF, 4'h0, 2'd2, 0, 1);
        addn(4, 1, 4'hF, 4'h8, 2'd3, 1, 0);
        addn(1, 1, 4'hF, 4'h0, 2'd3, 0, 1);
        addn(1, 1, 4'hF, 4'h1, 2'd0, 1, 0);
        addn(2, 1, 4'h0, 4'h0, 2'd0, 0, 0);
        addn(3, 1, 4'h4, 4'h4, 2'd2, 1, 0);
        addn(2, 1, 4'h0, 4'h0, 2'd2, 0, 0);
        addn(4, 1, 4'h2, 4'h2, 2'd1, 1, 0);
        addn(1, 1, 4'h4, 4'h0, 2'd1, 0, 0);
        addn(1, 1, 4'h4, 4'h4, 2'd2, 1, 0);
        addn(2, 1, 4'h0, 4'h0, 2'd2, 0, 0);
        addn(3, 1, 4'h8, 4'h8, 2'd3, 1, 0);
        addn(1, 0, 4'h8, 4'h0, 2'd0, 0, 0);
        addn(1, 1, 4'hA, 4'h2, 2'd1, 1, 0);
        addn(1, 1, 4'h0, 4'h0, 2'd1, 0, 0);
`endif

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_n   = tbl[i].rst_n;
            bus.req = tbl[i].req;
            step();
            nvec++;
            if ({bus.gnt, bus.sel, bus.busy, bus.preempt} !==
                {tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].pre}) begin
                nerr++;
                $display("FAIL vec%0d: got gnt=%b sel=%b busy=%b pre=%b want gnt=%b sel=%b busy=%b pre=%b",
                         i, bus.gnt, bus.sel, bus.busy, bus.preempt,
                         tbl[i].gnt, tbl[i].sel, tbl[i].busy, tbl[i].pre);
            end
        end

`ifdef MUX41_ARB_PRIO0_EN
        begin
            int n = 0;
            int p = 0;
            @(negedge clk);
            bus.req = 4'b0001;
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus.gnt == 4'b0001) n++;
                if (bus.preempt) p++;
            end
            chk("prio0_hold_cycles", n, 20);
            chk("prio0_preempts", p, 0);
            @(negedge clk);
            bus.req = 4'b0000;
            step();
            chk("prio0_release", {bus.gnt, bus.preempt}, 0);
        end
`else
        begin
            int n = 0;
            int w = 0;
            @(negedge clk);
            bus.req = 4'b0001;
            while (bus.gnt != 4'b0001 && w < 10) begin
                step();
                w++;
            end
            chk("solo_grant_timeout", int'(w < 10), 1);
            while (bus.gnt == 4'b0001 && n < 300) begin
                n++;
                step();
            end
            chk("solo_hold_cycles", n, MH);
            chk("solo_preempt", int'(bus.preempt), 1);
            chk("solo_gap_gnt", int'(bus.gnt), 0);
            step();
            chk("solo_rewin_gnt", int'(bus.gnt), 1);
            chk("solo_rewin_pre", int'(bus.preempt), 0);
            @(negedge clk);
            bus.req = 4'b0000;
            step();
            chk("solo_drop_busy", int'(bus.busy), 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
